player_state_fsm: RTL and testbench

- Per-player character state machine, directly upstream of the sprite renderer. Its 3-bit state output drives the renderer's state input unchanged.
- Converts debounced button levels into the movement and attack state sequence once per game frame.
- Times the three attack phases (start / active / recovery) with a frame counter.
- One instance per player; the FACING parameter selects which button means "forward".

---
 rtl/player_state_fsm.sv | 158 +++++++++++++++
 tb/tb_player_state_fsm.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/player_state_fsm.sv
// Per-player character state machine feeding the sprite renderer.
// Button levels are turned into movement and attack states once per game
// frame. A frame counter times the three attack phases.
//
//   state | meaning
//   ------+----------------------------------------------
//   0     | IDLE: no movement, or both directions held
//   1     | Backward: only the backward button held
//   2     | Forward: only the forward button held
//   3     | Attack_start: wind-up, STARTUP_FRAMES ticks
//   4     | Attack_active: hit frames, ACTIVE_FRAMES ticks
//   5     | Attack_recovery: cool-down, RECOVERY_FRAMES ticks
module player_state_fsm #(
  parameter bit          FACING_RIGHT    = 1'b1,
  parameter int unsigned STARTUP_FRAMES  = 4,
  parameter int unsigned ACTIVE_FRAMES   = 2,
  parameter int unsigned RECOVERY_FRAMES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_attack,
  output logic [2:0] state,
  output logic [5:0] frame_cnt,
  output logic       attack_active,
  output logic       busy
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_BACK       = 3'd1,
    ST_FWD        = 3'd2,
    ST_ATK_START  = 3'd3,
    ST_ATK_ACTIVE = 3'd4,
    ST_ATK_RECOV  = 3'd5
  } state_e;

  // Each phase ends on the tick where the counter already holds DUR-1.
  localparam logic [5:0] STARTUP_LAST  = 6'(STARTUP_FRAMES - 1);
  localparam logic [5:0] ACTIVE_LAST   = 6'(ACTIVE_FRAMES - 1);
  localparam logic [5:0] RECOVERY_LAST = 6'(RECOVERY_FRAMES - 1);

  state_e     state_q, state_d;
  logic [5:0] frame_cnt_q, frame_cnt_d;
  logic       attack_active_q, attack_active_d;
  logic       busy_q, busy_d;
  logic       attack_pending_q, attack_pending_d;
  logic       atk_prev_q, atk_prev_d;

  logic       fwd;
  logic       back;
  logic       atk_rise;
  logic       atk_req;
  state_e     move_state;

  // Map physical buttons to forward/backward and pick the movement state.
  always_comb begin
    fwd        = FACING_RIGHT ? btn_right : btn_left;
    back       = FACING_RIGHT ? btn_left  : btn_right;
    move_state = ST_IDLE;
    if (fwd && !back) begin
      move_state = ST_FWD;
    end else if (back && !fwd) begin
      move_state = ST_BACK;
    end
  end

  // Attack press detection: an edge in the same clk as the tick still counts.
  always_comb begin
    atk_rise         = btn_attack & ~atk_prev_q;
    atk_req          = attack_pending_q | atk_rise;
    atk_prev_d       = btn_attack;
    // The buffer only lives until the next tick, so presses made while
    // attacking are dropped at that tick instead of queueing a new attack.
    attack_pending_d = frame_tick ? 1'b0 : (attack_pending_q | atk_rise);
  end

  // Next-state and frame counter; everything holds between frame ticks.
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    if (frame_tick) begin
      case (state_q)
        ST_IDLE, ST_BACK, ST_FWD: begin
          frame_cnt_d = 6'd0;
          if (atk_req) begin
            state_d = ST_ATK_START;
          end else begin
            state_d = move_state;
          end
        end
        ST_ATK_START: begin
          if (frame_cnt_q == STARTUP_LAST) begin
            state_d     = ST_ATK_ACTIVE;
            frame_cnt_d = 6'd0;
          end else begin
            frame_cnt_d = frame_cnt_q + 6'd1;
          end
        end
        ST_ATK_ACTIVE: begin
          if (frame_cnt_q == ACTIVE_LAST) begin
            state_d     = ST_ATK_RECOV;
            frame_cnt_d = 6'd0;
          end else begin
            frame_cnt_d = frame_cnt_q + 6'd1;
          end
        end
        ST_ATK_RECOV: begin
          if (frame_cnt_q == RECOVERY_LAST) begin
            state_d     = move_state;
            frame_cnt_d = 6'd0;
          end else begin
            frame_cnt_d = frame_cnt_q + 6'd1;
          end
        end
        default: begin
          state_d     = ST_IDLE;
          frame_cnt_d = 6'd0;
        end
      endcase
    end
  end

  // Status flags are derived from the next state so they land with it.
  always_comb begin
    attack_active_d = (state_d == ST_ATK_ACTIVE);
    busy_d          = (state_d == ST_ATK_START) ||
                      (state_d == ST_ATK_ACTIVE) ||
                      (state_d == ST_ATK_RECOV);
  end

  // Single register stage for state, counter, flags and the attack buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      frame_cnt_q      <= 6'd0;
      attack_active_q  <= 1'b0;
      busy_q           <= 1'b0;
      attack_pending_q <= 1'b0;
      atk_prev_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      frame_cnt_q      <= frame_cnt_d;
      attack_active_q  <= attack_active_d;
      busy_q           <= busy_d;
      attack_pending_q <= attack_pending_d;
      atk_prev_q       <= atk_prev_d;
    end
  end

  assign state         = state_q;
  assign frame_cnt     = frame_cnt_q;
  assign attack_active = attack_active_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_player_state_fsm.sv
// Bench for player_state_fsm: one right-facing and one left-facing instance
// share the same buttons; directed scenarios plus a random run against a
// tick-count model of the attack.
module tb_player_state_fsm;

  localparam int S     = 4;
  localparam int A     = 2;
  localparam int R     = 8;
  localparam int TOTAL = S + A + R;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       btn_left = 1'b0;
  logic       btn_right = 1'b0;
  logic       btn_attack = 1'b0;
  logic [2:0] state0, state1;
  logic [5:0] cnt0, cnt1;
  logic       act0, act1, busy0, busy1;

  int checks = 0;
  int failures = 0;

  // Reference model: attack tracked as "ticks since entry", movement per instance.
  bit m_prev, m_pend, m_att;
  int m_idx;
  int m_mov[2];

  player_state_fsm #(.FACING_RIGHT(1'b1), .STARTUP_FRAMES(S), .ACTIVE_FRAMES(A),
                     .RECOVERY_FRAMES(R)) dut0 (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .btn_left(btn_left),
    .btn_right(btn_right), .btn_attack(btn_attack), .state(state0),
    .frame_cnt(cnt0), .attack_active(act0), .busy(busy0));

  player_state_fsm #(.FACING_RIGHT(1'b0), .STARTUP_FRAMES(S), .ACTIVE_FRAMES(A),
                     .RECOVERY_FRAMES(R)) dut1 (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .btn_left(btn_left),
    .btn_right(btn_right), .btn_attack(btn_attack), .state(state1),
    .frame_cnt(cnt1), .attack_active(act1), .busy(busy1));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int dir_of(int i);
    bit f, b;
    f = (i == 0) ? btn_right : btn_left;
    b = (i == 0) ? btn_left : btn_right;
    if (f && !b) return 2;
    if (b && !f) return 1;
    return 0;
  endfunction

  function automatic int exp_state(int i);
    if (!m_att) return m_mov[i];
    if (m_idx < S) return 3;
    if (m_idx < S + A) return 4;
    return 5;
  endfunction

  function automatic int exp_cnt();
    if (!m_att) return 0;
    if (m_idx < S) return m_idx;
    if (m_idx < S + A) return m_idx - S;
    return m_idx - S - A;
  endfunction

  task automatic model_reset();
    m_prev = 0; m_pend = 0; m_att = 0; m_idx = 0;
    m_mov[0] = 0; m_mov[1] = 0;
  endtask

  task automatic model_update();
    bit rise;
    rise = btn_attack && !m_prev;
    if (frame_tick) begin
      if (m_att) begin
        if (m_idx == TOTAL - 1) begin
          m_att = 0;
          m_mov[0] = dir_of(0);
          m_mov[1] = dir_of(1);
        end else begin
          m_idx++;
        end
      end else if (m_pend || rise) begin
        m_att = 1;
        m_idx = 0;
      end else begin
        m_mov[0] = dir_of(0);
        m_mov[1] = dir_of(1);
      end
      m_pend = 0;
    end else begin
      m_pend = m_pend || rise;
    end
    m_prev = btn_attack;
  endtask

  // One clk: drive tick, take the edge, advance the model, sample 1ns later.
  task automatic step(input bit tick);
    frame_tick = tick;
    @(posedge clk);
    model_update();
    #1;
    frame_tick = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    #12;
    checks++; if (state0 !== 3'd0) begin failures++; $display("FAIL reset_state: got %0d expected 0", state0); end
    checks++; if (cnt0 !== 6'd0) begin failures++; $display("FAIL reset_cnt: got %0d expected 0", cnt0); end
    checks++; if (act0 !== 1'b0) begin failures++; $display("FAIL reset_active: got %0d expected 0", act0); end
    checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0d expected 0", busy0); end
    checks++; if (state1 !== 3'd0) begin failures++; $display("FAIL reset_state1: got %0d expected 0", state1); end
    rst_n = 1'b1;
  endtask

  task automatic test_movement();
    btn_right = 1'b1;
    step(0);
    checks++; if (state0 !== 3'd0) begin failures++; $display("FAIL move_hold_no_tick: got %0d expected 0", state0); end
    step(1);
    checks++; if (state0 !== 3'd2) begin failures++; $display("FAIL move_fwd: got %0d expected 2", state0); end
    checks++; if (state1 !== 3'd1) begin failures++; $display("FAIL move_back_mirror: got %0d expected 1", state1); end
    checks++; if (busy0 !== 1'b0 || cnt0 !== 6'd0) begin failures++; $display("FAIL move_flags: busy %0d cnt %0d expected 0 0", busy0, cnt0); end
    step(0); step(1); step(0); step(1);
    checks++; if (state0 !== 3'd2) begin failures++; $display("FAIL move_fwd_held: got %0d expected 2", state0); end
    btn_left = 1'b1;
    step(1);
    checks++; if (state0 !== 3'd0) begin failures++; $display("FAIL move_both: got %0d expected 0", state0); end
    btn_right = 1'b0;
    step(1);
    checks++; if (state0 !== 3'd1) begin failures++; $display("FAIL move_back: got %0d expected 1", state0); end
    btn_left = 1'b0;
    step(1);
    step(0);
  endtask

  task automatic test_attack_timing();
    int first4 = -1, first5 = -1, first0 = -1, n_active = 0;
    int rec_cnt[$];
    bit busy_ok = 1, rec_ok;
    btn_attack = 1'b1;
    repeat (4) step(0);
    step(1);
    checks++; if (state0 !== 3'd3 || cnt0 !== 6'd0) begin failures++; $display("FAIL atk_entry: state %0d cnt %0d expected 3 0", state0, cnt0); end
    btn_attack = 1'b0;
    for (int t = 1; t <= 30; t++) begin
      step(0); step(0); step(1);
      if (state0 == 3'd4 && first4 < 0) first4 = t;
      if (state0 == 3'd5 && first5 < 0) first5 = t;
      if (act0 === 1'b1) n_active++;
      if (state0 == 3'd5) rec_cnt.push_back(int'(cnt0));
      if (busy0 !== (state0 >= 3'd3 && state0 <= 3'd5)) busy_ok = 0;
      if (state0 == 3'd0) begin first0 = t; break; end
    end
    checks++; if (first4 != S) begin failures++; $display("FAIL atk_to_active: got %0d ticks expected %0d", first4, S); end
    checks++; if (first5 != S + A) begin failures++; $display("FAIL atk_to_recovery: got %0d ticks expected %0d", first5, S + A); end
    checks++; if (first0 != TOTAL) begin failures++; $display("FAIL atk_to_idle: got %0d ticks expected %0d", first0, TOTAL); end
    checks++; if (n_active != A) begin failures++; $display("FAIL atk_active_len: got %0d expected %0d", n_active, A); end
    rec_ok = (rec_cnt.size() == R);
    foreach (rec_cnt[k]) if (rec_cnt[k] != k) rec_ok = 0;
    checks++; if (!rec_ok) begin failures++; $display("FAIL atk_recovery_cnt: got %0d entries expected 0..%0d in order", rec_cnt.size(), R - 1); end
    checks++; if (!busy_ok) begin failures++; $display("FAIL atk_busy_track: got mismatch expected busy==(state in 3..5)"); end
  endtask

  task automatic test_hold();
    int entries;
    logic [2:0] prev;
    btn_attack = 1'b0;
    step(0);
    btn_attack = 1'b1;
    step(1);
    entries = (state0 == 3'd3) ? 1 : 0;
    prev = state0;
    for (int t = 1; t <= TOTAL + 3; t++) begin
      step(0); step(1);
      if (state0 == 3'd3 && prev != 3'd3) entries++;
      prev = state0;
    end
    checks++; if (entries != 1) begin failures++; $display("FAIL hold_one_attack: got %0d attacks expected 1", entries); end
    checks++; if (state0 !== 3'd0 || busy0 !== 1'b0) begin failures++; $display("FAIL hold_final: state %0d busy %0d expected 0 0", state0, busy0); end
    btn_attack = 1'b0;
    step(0);
  endtask

  task automatic test_buffer_discard();
    btn_attack = 1'b1;
    step(1);
    btn_attack = 1'b0;
    repeat (TOTAL - 1) begin step(0); step(1); end
    checks++; if (state0 !== 3'd5 || cnt0 !== 6'd7) begin failures++; $display("FAIL buf_last_frame: state %0d cnt %0d expected 5 7", state0, cnt0); end
    btn_attack = 1'b1;
    step(0); step(0);
    btn_attack = 1'b0;
    step(0); step(1);
    checks++; if (state0 !== 3'd0) begin failures++; $display("FAIL buf_exit: got %0d expected 0", state0); end
    step(0); step(1);
    checks++; if (state0 !== 3'd0 || busy0 !== 1'b0) begin failures++; $display("FAIL buf_discarded: state %0d busy %0d expected 0 0", state0, busy0); end
    btn_attack = 1'b1;
    step(1);
    btn_attack = 1'b0;
    repeat (TOTAL - 1) begin step(0); step(1); end
    btn_right = 1'b1;
    btn_attack = 1'b1;
    step(1);
    checks++; if (state0 !== 3'd2) begin failures++; $display("FAIL exit_tick_press: got %0d expected 2", state0); end
    step(0); step(1);
    checks++; if (state0 !== 3'd2) begin failures++; $display("FAIL exit_press_dropped: got %0d expected 2", state0); end
    btn_right = 1'b0;
    btn_attack = 1'b0;
    step(1); step(0);
  endtask

  task automatic test_facing();
    btn_left = 1'b1;
    step(0); step(1);
    checks++; if (state1 !== 3'd2) begin failures++; $display("FAIL facing_left_fwd: got %0d expected 2", state1); end
    checks++; if (state0 !== 3'd1) begin failures++; $display("FAIL facing_right_back: got %0d expected 1", state0); end
    btn_attack = 1'b1;
    step(1);
    checks++; if (state1 !== 3'd3) begin failures++; $display("FAIL facing_priority: got %0d expected 3", state1); end
    btn_attack = 1'b0;
    repeat (TOTAL - 1) begin step(0); step(1); end
    step(0); step(1);
    checks++; if (state1 !== 3'd2) begin failures++; $display("FAIL facing_exit_fwd: got %0d expected 2", state1); end
    checks++; if (state0 !== 3'd1) begin failures++; $display("FAIL facing_exit_back: got %0d expected 1", state0); end
    btn_left = 1'b0;
    step(1); step(0);
  endtask

  task automatic test_reset_mid_attack();
    btn_attack = 1'b1;
    step(1);
    btn_attack = 1'b0;
    repeat (S) begin step(0); step(1); end
    checks++; if (state0 !== 3'd4 || act0 !== 1'b1) begin failures++; $display("FAIL pre_reset_active: state %0d active %0d expected 4 1", state0, act0); end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (state0 !== 3'd0) begin failures++; $display("FAIL async_reset_state: got %0d expected 0", state0); end
    checks++; if (cnt0 !== 6'd0) begin failures++; $display("FAIL async_reset_cnt: got %0d expected 0", cnt0); end
    checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL async_reset_busy: got %0d expected 0", busy0); end
    checks++; if (act0 !== 1'b0) begin failures++; $display("FAIL async_reset_active: got %0d expected 0", act0); end
    #2;
    rst_n = 1'b1;
    step(0);
  endtask

  task automatic test_random();
    int es0, es1, ec;
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 7) == 0) btn_attack = ~btn_attack;
      if ($urandom_range(0, 9) == 0) btn_left = ~btn_left;
      if ($urandom_range(0, 9) == 0) btn_right = ~btn_right;
      step($urandom_range(0, 2) == 0);
      es0 = exp_state(0);
      es1 = exp_state(1);
      ec  = exp_cnt();
      checks++; if (int'(state0) != es0) begin failures++; $display("FAIL rnd_state0 @%0d: got %0d expected %0d", n, state0, es0); end
      checks++; if (int'(state1) != es1) begin failures++; $display("FAIL rnd_state1 @%0d: got %0d expected %0d", n, state1, es1); end
      checks++; if (int'(cnt0) != ec) begin failures++; $display("FAIL rnd_cnt0 @%0d: got %0d expected %0d", n, cnt0, ec); end
      checks++; if (int'(cnt1) != ec) begin failures++; $display("FAIL rnd_cnt1 @%0d: got %0d expected %0d", n, cnt1, ec); end
      checks++; if (act0 !== (es0 == 4)) begin failures++; $display("FAIL rnd_active0 @%0d: got %0d expected %0d", n, act0, es0 == 4); end
      checks++; if (busy0 !== (es0 >= 3)) begin failures++; $display("FAIL rnd_busy0 @%0d: got %0d expected %0d", n, busy0, es0 >= 3); end
      checks++; if (act1 !== (es1 == 4)) begin failures++; $display("FAIL rnd_active1 @%0d: got %0d expected %0d", n, act1, es1 == 4); end
      checks++; if (busy1 !== (es1 >= 3)) begin failures++; $display("FAIL rnd_busy1 @%0d: got %0d expected %0d", n, busy1, es1 >= 3); end
    end
  endtask

  initial begin
    test_reset();
    test_movement();
    test_attack_timing();
    test_hold();
    test_buffer_discard();
    test_facing();
    test_reset_mid_attack();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
